// File: rtl/bus_wait_ctl.sv
// Bus cycle wait-state controller: decodes the mapped address, drives registered chip selects
// and holds the CPU (ready low) for fixed RAM/ROM wait states or until an IO device acknowledges.
module bus_wait_ctl #(
  parameter int RAM_WAIT   = 0,
  parameter int ROM_WAIT   = 1,
  parameter int IO_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] address_next,
  input  logic        map_next,
  input  logic        req,
  input  logic        we,
  input  logic        io_ack,
  input  logic        err_clr,
  output logic        ready,
  output logic [19:0] bus_addr,
  output logic        bus_we,
  output logic        bus_mapped,
  output logic        cs_ram,
  output logic        cs_rom,
  output logic        cs_io,
  output logic        bus_error
);

  localparam logic [2:0] RAM_W   = 3'(RAM_WAIT);
  localparam logic [2:0] ROM_W   = 3'(ROM_WAIT);
  localparam logic [4:0] TO_LAST = 5'(IO_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_IO_WAIT = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [2:0]  wait_cnt;
  logic [4:0]  to_cnt;
  logic [2:0]  sel;
  logic        capture;
  logic        timeout;

  // Returns {io, rom, ram}; at most one bit set, none for unmapped space.
  function automatic logic [2:0] decode(input logic [19:0] a);
    logic [2:0] r;
    r = 3'b000;
    if (a[19:17] == 3'd0)
      r = 3'b001;
    else if (a[19:17] == 3'd1)
      r = 3'b010;
    else if (a[19:12] == 8'hFD)
      r = 3'b100;
    return r;
  endfunction

  assign sel     = decode(address_next);
  assign capture = (state == S_IDLE);
  assign timeout = (state == S_IO_WAIT) && !io_ack && (to_cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE: begin
        if (req) begin
          if (sel[2])
            state_next = S_IO_WAIT;
          else if (sel[1] && (ROM_W != 3'd0))
            state_next = S_WAIT;
          else if (sel[0] && (RAM_W != 3'd0))
            state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (wait_cnt == 3'd1)
          state_next = S_IDLE;
      end
      S_IO_WAIT: begin
        // An ack in the final cycle still completes cleanly; only the error flag depends on it.
        if (io_ack || (to_cnt == TO_LAST))
          state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    ready = (state == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= 3'd0;
      to_cnt   <= 3'd0;
    end else begin
      unique case (state)
        S_IDLE: begin
          wait_cnt <= (state_next == S_WAIT) ? (sel[1] ? ROM_W : RAM_W) : 3'd0;
          to_cnt   <= 5'd0;
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt - 3'd1;
        end
        S_IO_WAIT: begin
          if (!io_ack && (to_cnt != TO_LAST))
            to_cnt <= to_cnt + 5'd1;
          else
            to_cnt <= 5'd0;
        end
        default: begin
          wait_cnt <= 3'd0;
          to_cnt   <= 5'd0;
        end
      endcase
    end
  end

  // Bus-side outputs only move at a capture edge, so they stay stable for the whole access.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus_addr   <= 20'd0;
      bus_we     <= 1'b0;
      bus_mapped <= 1'b0;
      cs_ram     <= 1'b0;
      cs_rom     <= 1'b0;
      cs_io      <= 1'b0;
    end else if (capture) begin
      bus_addr   <= address_next;
      bus_we     <= we;
      bus_mapped <= map_next;
      cs_ram     <= req & sel[0];
      cs_rom     <= req & sel[1];
      cs_io      <= req & sel[2];
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      bus_error <= 1'b0;
    else if (timeout)
      bus_error <= 1'b1;
    else if (err_clr)
      bus_error <= 1'b0;
  end

endmodule
